// File: rtl/incr_arbiter_pkg.sv
// Shared sizes, FSM encoding and the round-robin pick for the incrementer arbiter.
package incr_arbiter_pkg;

    localparam int N_CH  = 4;
    localparam int W     = 4;
    localparam int PTR_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    // First requester at or after ptr, wrapping modulo N_CH; scanned
    // backwards so the nearest candidate is the last one written.
    function automatic logic [PTR_W-1:0] rr_pick(
        input logic [N_CH-1:0]  req,
        input logic [PTR_W-1:0] ptr
    );
        logic [PTR_W-1:0] pick;
        logic [PTR_W-1:0] idx;
        pick = ptr;
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx = ptr + PTR_W'(k);
            if (req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/incr_arbiter_add_by_one.sv
// Shared datapath: a W-bit add-by-one with carry-out used to detect a 15->0 wrap.
module add_by_one
    import incr_arbiter_pkg::*;
(
    input  logic [W-1:0] a,
    output logic [W-1:0] sum,
    output logic         carry
);

    assign {carry, sum} = {1'b0, a} + (W+1)'(1);

endmodule

// File: rtl/incr_arbiter.sv
// Four counters sharing one incrementer; a two-state FSM grants one channel per
// IDLE/EXEC pair, round-robin, and writes the sum back at the end of EXEC.
module incr_arbiter
    import incr_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   req,
    input  logic [N_CH-1:0]   clr,
    output logic [N_CH-1:0]   gnt,
    output logic [N_CH*W-1:0] cnt,
    output logic [N_CH-1:0]   ovf,
    output logic              busy
);

    state_t           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] win_q, win_d;
    logic [W-1:0]     cnt_q [N_CH];
    logic [W-1:0]     cnt_d [N_CH];
    logic [N_CH-1:0]  ovf_q, ovf_d;

    logic [W-1:0]     inc_operand;
    logic [W-1:0]     inc_sum;
    logic             inc_carry;

    assign inc_operand = cnt_q[win_q];

    add_by_one u_add_by_one (
        .a     (inc_operand),
        .sum   (inc_sum),
        .carry (inc_carry)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    win_d   = rr_pick(req, ptr_q);
                    ptr_d   = win_d + PTR_W'(1);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Clear beats a coinciding write-back; everything else holds.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            ovf_d[i] = ovf_q[i];
            if (clr[i]) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if ((state_q == EXEC) && (win_q == PTR_W'(i))) begin
                cnt_d[i] = inc_sum;
                if (inc_carry) begin
                    ovf_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            ovf_q   <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            ovf_q   <= ovf_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_out
            assign cnt[gi*W +: W] = cnt_q[gi];
            assign gnt[gi]        = (state_q == EXEC) && (win_q == PTR_W'(gi));
        end
    endgenerate

    assign ovf  = ovf_q;
    assign busy = (state_q == EXEC);

endmodule
